hilo_divider: RTL and testbench

Iterative multi-cycle divide unit that executes MIPS `div`/`divu` and owns the HI/LO result registers read by `mfhi`/`mflo`. It sits beside the Execute stage:
- Execute launches an operation with a one-cycle `start`.
- The unit's `busy` output is ORed into the hazard unit's mfhi/mflo stall condition alongside HasDivE/M/W.
- Decode reads `hi_out`/`lo_out` once `busy` is low.

---
 rtl/hilo_divider_pkg.sv | 21 ++
 rtl/hilo_divider_if.sv | 25 ++
 rtl/hilo_divider_div_step.sv | 26 ++
 rtl/hilo_divider.sv | 179 +++++++++++++++++
 tb/tb_hilo_divider.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/hilo_divider_pkg.sv
// Shared constants for the HI/LO divide unit: FSM encodings and divide-by-zero fill.
package hilo_divider_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    typedef enum logic [2:0] {
        DIV_IDLE = 3'd0,
        DIV_PREP = 3'd1,
        DIV_RUN  = 3'd2,
        DIV_FIX  = 3'd3,
        DIV_DONE = 3'd4
    } div_state_e;

    // LO is filled with this bit on a divide by zero
    localparam logic DIV_ZERO_LO_BIT = 1'b1;

    function automatic logic is_busy_state(input div_state_e s);
        return (s == DIV_PREP) || (s == DIV_RUN) || (s == DIV_FIX);
    endfunction

endpackage

// File: rtl/hilo_divider_if.sv
// Launch/result bundle between Execute/Decode (master) and the HI/LO divider (slave).
interface hilo_divider_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             div_by_zero;

    modport master (
        output start, signed_op, dividend, divisor, cancel,
        input  busy, done, hi_out, lo_out, div_by_zero
    );

    modport slave (
        input  start, signed_op, dividend, divisor, cancel,
        output busy, done, hi_out, lo_out, div_by_zero
    );
endinterface

// File: rtl/hilo_divider_div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quo_o
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // MSB of the trial result is the borrow: set means the divisor did not fit
    always_comb begin
        shifted = (rem_i << 1) | {{WIDTH{1'b0}}, quo_i[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_i};
        if (trial[WIDTH]) begin
            rem_o = shifted;
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end else begin
            rem_o = trial;
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end
    end
endmodule

// File: rtl/hilo_divider.sv
// Iterative div/divu unit owning HI/LO; WIDTH restoring steps between PREP and FIX.
// Define HILO_DIV_SIGNED_EN to honour signed_op (magnitude conversion and sign fix-up).
module hilo_divider
    import hilo_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    hilo_divider_if.slave div_if
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] raw_a_q, raw_a_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_out_q, dz_out_d;
`ifdef HILO_DIV_SIGNED_EN
    logic             sgn_q, sgn_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
`endif

    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quo;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= DIV_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            raw_a_q  <= '0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_out_q <= 1'b0;
`ifdef HILO_DIV_SIGNED_EN
            sgn_q    <= 1'b0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            raw_a_q  <= raw_a_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dz_out_q <= dz_out_d;
`ifdef HILO_DIV_SIGNED_EN
            sgn_q    <= sgn_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        raw_a_d = raw_a_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef HILO_DIV_SIGNED_EN
        sgn_d   = sgn_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
`endif

        case (state_q)
            DIV_IDLE, DIV_DONE: begin
                state_d = DIV_IDLE;
                // cancel here only suppresses a coincident launch
                if (div_if.start && !div_if.cancel) begin
                    state_d = DIV_PREP;
                    quo_d   = div_if.dividend;
                    dvs_d   = div_if.divisor;
                    raw_a_d = div_if.dividend;
                    dz_d    = (div_if.divisor == '0);
`ifdef HILO_DIV_SIGNED_EN
                    sgn_d   = div_if.signed_op;
`endif
                end
            end

            DIV_PREP: begin
                if (div_if.cancel) begin
                    state_d = DIV_IDLE;
                end else begin
                    state_d = DIV_RUN;
                    rem_d   = '0;
                    cnt_d   = CNT_W'(WIDTH - 1);
`ifdef HILO_DIV_SIGNED_EN
                    negq_d  = 1'b0;
                    negr_d  = 1'b0;
                    if (sgn_q) begin
                        if (quo_q[WIDTH-1]) quo_d = -quo_q;
                        if (dvs_q[WIDTH-1]) dvs_d = -dvs_q;
                        negq_d = quo_q[WIDTH-1] ^ dvs_q[WIDTH-1];
                        negr_d = quo_q[WIDTH-1];
                    end
`endif
                end
            end

            DIV_RUN: begin
                if (div_if.cancel) begin
                    state_d = DIV_IDLE;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == '0) state_d = DIV_FIX;
                end
            end

            DIV_FIX: begin
                if (div_if.cancel) begin
                    state_d = DIV_IDLE;
                end else begin
                    state_d = DIV_DONE;
                    if (dz_q) begin
                        hi_d = raw_a_q;
                        lo_d = {WIDTH{DIV_ZERO_LO_BIT}};
                    end else begin
                        hi_d = rem_q[WIDTH-1:0];
                        lo_d = quo_q;
`ifdef HILO_DIV_SIGNED_EN
                        if (negr_q) hi_d = -rem_q[WIDTH-1:0];
                        if (negq_q) lo_d = -quo_q;
`endif
                    end
                end
            end

            default: state_d = DIV_IDLE;
        endcase

        busy_d   = is_busy_state(state_d);
        done_d   = (state_d == DIV_DONE);
        dz_out_d = (state_d == DIV_DONE) && dz_q;
    end

    assign div_if.busy        = busy_q;
    assign div_if.done        = done_q;
    assign div_if.hi_out      = hi_q;
    assign div_if.lo_out      = lo_q;
    assign div_if.div_by_zero = dz_out_q;

endmodule

// File: tb/tb_hilo_divider.sv
// Scoreboard bench for hilo_divider: stimulus pushes expected results, a monitor checks each done.
module tb_hilo_divider;
    localparam int unsigned W = 32;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           due;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   hold_skip = 1'b0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hilo_divider_if #(.WIDTH(W)) dif ();

    hilo_divider #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .div_if (dif)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic set_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        dif.start     = 1'b1;
        dif.dividend  = a;
        dif.divisor   = b;
        dif.signed_op = s;
    endtask

    task automatic push(input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dz, input int due);
        exp_t e;
        e.hi = hi; e.lo = lo; e.dz = dz; e.due = due;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz);
        @(negedge clk);
        set_op(a, b, s);
        push(ehi, elo, edz, cyc + 35);
        @(negedge clk);
        dif.start = 1'b0;
        wait_drain(60);
    endtask

    // Monitor: pops on every done, and checks HI/LO hold and div_by_zero quiet otherwise
    initial begin : monitor
        logic [W-1:0] hi_p, lo_p;
        exp_t e;
        hi_p = '0;
        lo_p = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (dif.done) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done actual=1 required=0 (cyc=%0d)", cyc);
                    end else begin
                        e = sb.pop_front();
                        chk("done_cycle", W'(cyc), W'(e.due));
                        chk("hi", dif.hi_out, e.hi);
                        chk("lo", dif.lo_out, e.lo);
                        chk("div_by_zero", W'(dif.div_by_zero), W'(e.dz));
                    end
                end else begin
                    chk("dz_outside_done", W'(dif.div_by_zero), '0);
                    if (!hold_skip) begin
                        chk("hi_hold", dif.hi_out, hi_p);
                        chk("lo_hold", dif.lo_out, lo_p);
                    end
                end
            end
            hi_p = dif.hi_out;
            lo_p = dif.lo_out;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        reset         = 1'b1;
        dif.start     = 1'b0;
        dif.signed_op = 1'b0;
        dif.dividend  = '0;
        dif.divisor   = '0;
        dif.cancel    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", W'(dif.busy), '0);
        chk("rst_done", W'(dif.done), '0);
        chk("rst_dz", W'(dif.div_by_zero), '0);
        chk("rst_hi", dif.hi_out, '0);
        chk("rst_lo", dif.lo_out, '0);
        reset = 1'b0;

        // 100/7 with busy profile, ignored restart at cycle 5, relaunch (5/0) in DONE
        @(negedge clk);
        set_op(32'd100, 32'd7, 1'b0);
        n = cyc;
        push(32'd2, 32'd14, 1'b0, n + 35);
        for (int c = 1; c <= 35; c++) begin
            @(negedge clk);
            dif.start = 1'b0;
            chk($sformatf("busy_c%0d", c), W'(dif.busy), W'(c <= 34));
            if (c == 5) set_op(32'd50, 32'd5, 1'b0);
            if (c == 35) begin
                set_op(32'd5, 32'd0, 1'b0);
                push(32'd5, 32'hFFFF_FFFF, 1'b1, cyc + 35);
            end
        end
        @(negedge clk);
        dif.start = 1'b0;
        chk("busy_after_relaunch", W'(dif.busy), W'(1));
        wait_drain(60);

`ifdef HILO_DIV_SIGNED_EN
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h8000_0000, 1'b0);
`else
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0000_0000, 1'b0);
`endif
        run_op(32'hFFFF_FFF9, 32'd2, 1'b0, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0);
        run_op(32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 1'b0);

        // 9/3 cancelled at cycle 10: no done, HI/LO keep 2/14
        @(negedge clk);
        set_op(32'd9, 32'd3, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            dif.start = 1'b0;
            if (c == 10) dif.cancel = 1'b1;
        end
        @(negedge clk);
        dif.cancel = 1'b0;
        chk("busy_after_cancel", W'(dif.busy), '0);
        repeat (40) @(negedge clk);
        chk("hi_after_cancel", dif.hi_out, 32'd2);
        chk("lo_after_cancel", dif.lo_out, 32'd14);

        // cancel with start in IDLE blocks the launch
        @(negedge clk);
        set_op(32'd9, 32'd3, 1'b0);
        dif.cancel = 1'b1;
        @(negedge clk);
        dif.start  = 1'b0;
        dif.cancel = 1'b0;
        chk("busy_blocked_start", W'(dif.busy), '0);
        repeat (40) @(negedge clk);

        // async reset mid-RUN clears outputs without waiting for a clock edge
        @(negedge clk);
        set_op(32'd1000, 32'd3, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            dif.start = 1'b0;
        end
        chk("busy_mid_run", W'(dif.busy), W'(1));
        hold_skip = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", W'(dif.busy), '0);
        chk("arst_done", W'(dif.done), '0);
        chk("arst_hi", dif.hi_out, '0);
        chk("arst_lo", dif.lo_out, '0);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        hold_skip = 1'b0;
        repeat (40) @(negedge clk);

        run_op(32'd1000, 32'd3, 1'b0, 32'd1, 32'd333, 1'b0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
